// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage: widths, load types, FSM states and
// EXE->MEM bus field offsets (also used by exe_stage / wb_stage).
package mem_stage_pkg;

    localparam int DATA_W   = 32;
    localparam int REG_AW   = 5;
    localparam int ES_BUS_W = 6 + REG_AW + 2 * DATA_W;
    localparam int MS_BUS_W = 1 + REG_AW + 2 * DATA_W;
    localparam int DS_BUS_W = 3 + REG_AW + DATA_W;

    localparam logic [2:0] LD_W  = 3'd0;
    localparam logic [2:0] LD_B  = 3'd1;
    localparam logic [2:0] LD_BU = 3'd2;
    localparam logic [2:0] LD_H  = 3'd3;
    localparam logic [2:0] LD_HU = 3'd4;

    // EXE->MEM bus: {mem_req, ld_type[2:0], res_from_mem, gr_we, dest, alu_result, pc}
    localparam int ES_PC_LSB       = 0;
    localparam int ES_ALU_LSB      = DATA_W;
    localparam int ES_DEST_LSB     = 2 * DATA_W;
    localparam int ES_GR_WE        = ES_DEST_LSB + REG_AW;
    localparam int ES_RES_FROM_MEM = ES_GR_WE + 1;
    localparam int ES_LD_LSB       = ES_GR_WE + 2;
    localparam int ES_MEM_REQ      = ES_LD_LSB + 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2,
        DROP = 2'd3
    } ms_state_e;

endpackage

// File: rtl/mem_stage_axi_if.sv
// Pipeline handshake and data buses around the MEM stage.
//  slave  : the MEM stage's view (consumes EXE bus / SRAM response, produces WB and ID buses)
//  master : the surrounding pipeline's view
interface mem_stage_axi_if;
    import mem_stage_pkg::*;

    logic                ws_allowin;
    logic                ms_allowin;
    logic                es_to_ms_valid;
    logic [ES_BUS_W-1:0] es_to_ms_bus;
    logic                ms_to_ws_valid;
    logic [MS_BUS_W-1:0] ms_to_ws_bus;
    logic                data_sram_data_ok;
    logic [DATA_W-1:0]   data_sram_rdata;
    logic                flush;
    logic [DS_BUS_W-1:0] ms_to_ds_bus;

    modport slave (
        input  ws_allowin, es_to_ms_valid, es_to_ms_bus,
               data_sram_data_ok, data_sram_rdata, flush,
        output ms_allowin, ms_to_ws_valid, ms_to_ws_bus, ms_to_ds_bus
    );

    modport master (
        output ws_allowin, es_to_ms_valid, es_to_ms_bus,
               data_sram_data_ok, data_sram_rdata, flush,
        input  ms_allowin, ms_to_ws_valid, ms_to_ws_bus, ms_to_ds_bus
    );

endinterface

// File: rtl/mem_stage_axi_load_align.sv
// Load data alignment and extension (combinational).
//  raw     : 32-bit word as returned by the data SRAM
//  off     : byte offset within the word (address[1:0])
//  ld_type : LD_W / LD_B / LD_BU / LD_H / LD_HU
//  result  : aligned, sign- or zero-extended load value
module load_align
    import mem_stage_pkg::*;
(
    input  logic [DATA_W-1:0] raw,
    input  logic [1:0]        off,
    input  logic [2:0]        ld_type,
    output logic [DATA_W-1:0] result
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = raw[7:0];
        case (off)
            2'd1:    byte_v = raw[15:8];
            2'd2:    byte_v = raw[23:16];
            2'd3:    byte_v = raw[31:24];
            default: byte_v = raw[7:0];
        endcase
        // Halfword misalignment is trapped in EXE, so only off[1] matters here.
        half_v = off[1] ? raw[31:16] : raw[15:0];
    end

    always_comb begin
        result = raw;
        case (ld_type)
            LD_B:    result = {{(DATA_W-8){byte_v[7]}}, byte_v};
            LD_BU:   result = {{(DATA_W-8){1'b0}}, byte_v};
            LD_H:    result = {{(DATA_W-16){half_v[15]}}, half_v};
            LD_HU:   result = {{(DATA_W-16){1'b0}}, half_v};
            default: result = raw;
        endcase
    end

endmodule

// File: rtl/mem_stage_axi.sv
// MEM pipeline stage between EXE and WB with a variable-latency data SRAM response.
//  clk, resetn : clock and synchronous active-low reset
//  io (slave)  : EXE bus in (es_to_ms_valid/bus, ms_allowin), WB bus out (ms_to_ws_valid/bus,
//                ws_allowin), SRAM response (data_sram_data_ok/rdata), flush from WB,
//                forwarding bus to ID (ms_to_ds_bus)
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | no response outstanding (empty, or holding a non-memory op)
// WAIT  | memory op in MEM, its data_ok not yet seen
// HOLD  | response arrived while WB stalled; data kept in buf_q
// DROP  | flushed while waiting; next data_ok belongs to a dead op
module mem_stage_axi
    import mem_stage_pkg::*;
(
    input  logic            clk,
    input  logic            resetn,
    mem_stage_axi_if.slave  io
);

    ms_state_e           state, state_nx;
    logic                ms_valid;
    logic                ms_ready_go;
    logic                latch;
    logic                enter_wait;
    logic                buf_load;
    logic                buf_valid;
    logic [DATA_W-1:0]   buf_q;
    // mem_req only steers the FSM at latch time, so it is not kept.
    logic [ES_BUS_W-2:0] bus_q;

    logic [DATA_W-1:0]   pc, alu_result, raw, aligned, final_result;
    logic [REG_AW-1:0]   dest;
    logic                gr_we, res_from_mem, fwd_ok;
    logic [2:0]          ld_type;

    assign pc           = bus_q[ES_PC_LSB +: DATA_W];
    assign alu_result   = bus_q[ES_ALU_LSB +: DATA_W];
    assign dest         = bus_q[ES_DEST_LSB +: REG_AW];
    assign gr_we        = bus_q[ES_GR_WE];
    assign res_from_mem = bus_q[ES_RES_FROM_MEM];
    assign ld_type      = bus_q[ES_LD_LSB +: 3];

    always_comb begin
        ms_ready_go = 1'b0;
        case (state)
            IDLE:    ms_ready_go = 1'b1;
            WAIT:    ms_ready_go = io.data_sram_data_ok;
            HOLD:    ms_ready_go = 1'b1;
            default: ms_ready_go = 1'b0;
        endcase
    end

    assign io.ms_allowin     = (!ms_valid && state != DROP) || (ms_ready_go && io.ws_allowin);
    assign io.ms_to_ws_valid = ms_valid && ms_ready_go && !io.flush;
    assign latch             = io.es_to_ms_valid && io.ms_allowin;
    // A flushed-in instruction is dead on arrival and owes no tracking.
    assign enter_wait        = latch && !io.flush && io.es_to_ms_bus[ES_MEM_REQ];

    always_comb begin
        state_nx = state;
        buf_load = 1'b0;
        case (state)
            IDLE: begin
                if (enter_wait) state_nx = WAIT;
            end
            WAIT: begin
                if (io.data_sram_data_ok) begin
                    if (io.flush) begin
                        state_nx = IDLE;
                    end else if (io.ws_allowin) begin
                        state_nx = enter_wait ? WAIT : IDLE;
                    end else begin
                        state_nx = HOLD;
                        buf_load = 1'b1;
                    end
                end else if (io.flush) begin
                    state_nx = DROP;
                end
            end
            HOLD: begin
                if (io.flush)           state_nx = IDLE;
                else if (io.ws_allowin) state_nx = enter_wait ? WAIT : IDLE;
            end
            default: begin
                if (io.data_sram_data_ok) state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= IDLE;
            ms_valid  <= 1'b0;
            buf_valid <= 1'b0;
            buf_q     <= '0;
            bus_q     <= '0;
        end else begin
            state     <= state_nx;
            buf_valid <= (state_nx == HOLD);
            if (buf_load) buf_q <= io.data_sram_rdata;
            if (io.flush)           ms_valid <= 1'b0;
            else if (io.ms_allowin) ms_valid <= io.es_to_ms_valid;
            if (latch) bus_q <= io.es_to_ms_bus[ES_BUS_W-2:0];
        end
    end

    assign raw = buf_valid ? buf_q : io.data_sram_rdata;

    load_align u_load_align (
        .raw     (raw),
        .off     (alu_result[1:0]),
        .ld_type (ld_type),
        .result  (aligned)
    );

    assign final_result    = res_from_mem ? aligned : alu_result;
    assign fwd_ok          = ms_valid && (!res_from_mem || ms_ready_go);
    assign io.ms_to_ws_bus = {gr_we, dest, final_result, pc};
    assign io.ms_to_ds_bus = {ms_valid, gr_we, dest, fwd_ok, final_result};

endmodule
